// File: rtl/fib_weight_gen.sv
// fib_weight_gen
// Produces a stream of Fibonacci-style terms f(k) = f(k-1) + f(k-2) from two
// seeds. One term is offered per cycle under a valid/ready handshake. An error
// input rolls the sequence back by one term. A run ends on carry out or after
// MAXK accepted terms.
//
// Handshake: a term is offered while out_valid=1. It is accepted on a rising
// edge where out_valid=1, out_ready=1 and err_flag=0. While out_ready=0 the
// offered term (s_out/b_out/k_out/ovf) stays stable. err_flag=1 in RUN takes
// priority over out_ready.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset (overrides start)
//   start      load seeds and begin/restart a run (highest priority after reset)
//   a_in,b_in  seeds f(k-2), f(k-1); sampled only when start=1
//   err_flag   retract one term (RUN only)
//   out_ready  consumer accepts the current term
//   out_valid  term outputs valid (RUN)
//   s_out      current term f(k), low W bits
//   b_out      f(k-1)
//   k_out      index of current term, 0 after start
//   ovf        carry out of the add that produced s_out
//   busy       RUN or BACK
//   dbg_state  FSM state: 0 IDLE, 1 RUN, 2 BACK, 3 DONE
module fib_weight_gen #(
  parameter int W     = 8,
  parameter int MAXK  = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             err_flag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     s_out,
  output logic [W-1:0]     b_out,
  output logic [CNT_W-1:0] k_out,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    BACK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_r, b_r, s_r;
  logic [W-1:0]     a_nxt, b_nxt, s_nxt;
  logic             c_r, c_nxt;
  logic [CNT_W-1:0] k_r, k_nxt;

  // W+1 bit sums so the carry falls out as the top bit.
  logic [W:0]       seed_sum;
  logic [W:0]       adv_sum;
  logic [CNT_W:0]   k_plus1;
  logic             last_term;

  assign seed_sum  = {1'b0, a_in} + {1'b0, b_in};
  assign adv_sum   = {1'b0, b_r} + {1'b0, s_r};
  assign k_plus1   = {1'b0, k_r} + {{CNT_W{1'b0}}, 1'b1};
  // Accepting this term ends the run: either it already overflowed or it is
  // the MAXK-th term.
  assign last_term = c_r || (k_plus1 == (CNT_W+1)'(MAXK));

  always_comb begin
    state_nxt = state;
    a_nxt     = a_r;
    b_nxt     = b_r;
    s_nxt     = s_r;
    c_nxt     = c_r;
    k_nxt     = k_r;
    if (start) begin
      a_nxt     = a_in;
      b_nxt     = b_in;
      s_nxt     = seed_sum[W-1:0];
      c_nxt     = seed_sum[W];
      k_nxt     = '0;
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        RUN: begin
          if (err_flag) begin
            // Step back one term: (A,B,S) = (f(k-2),f(k-1),f(k)) becomes
            // (f(k-3),f(k-2),f(k-1)), with f(k-3) = f(k-1) - f(k-2).
            if (k_r != '0) begin
              b_nxt     = a_r;
              a_nxt     = b_r - a_r;
              s_nxt     = b_r;
              c_nxt     = 1'b0;
              k_nxt     = k_r - 1'b1;
              state_nxt = BACK;
            end
          end else if (out_ready) begin
            if (last_term) begin
              state_nxt = DONE;
            end else begin
              a_nxt = b_r;
              b_nxt = s_r;
              s_nxt = adv_sum[W-1:0];
              c_nxt = adv_sum[W];
              k_nxt = k_r + 1'b1;
            end
          end
        end
        BACK:    state_nxt = RUN;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      c_r   <= 1'b0;
      k_r   <= '0;
    end else begin
      state <= state_nxt;
      a_r   <= a_nxt;
      b_r   <= b_nxt;
      s_r   <= s_nxt;
      c_r   <= c_nxt;
      k_r   <= k_nxt;
    end
  end

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN) || (state == BACK);
  assign s_out     = s_r;
  assign b_out     = b_r;
  assign k_out     = k_r;
  assign ovf       = c_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_fib_weight_gen.sv
module tb_fib_weight_gen;

  localparam int W     = 8;
  localparam int MAXK  = 24;
  localparam int CNT_W = 5;
  localparam int VW    = 3 + CNT_W + 2 * W;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     a_in, b_in;
  logic             err_flag;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     s_out, b_out;
  logic [CNT_W-1:0] k_out;
  logic             ovf;
  logic             busy;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  fib_weight_gen #(.W(W), .MAXK(MAXK), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .err_flag  (err_flag),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .s_out     (s_out),
    .b_out     (b_out),
    .k_out     (k_out),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 back, 3 done
  int           m_st;
  logic [W-1:0] m_a, m_b, m_s;
  logic         m_c;
  int           m_k;

  task automatic model_edge(input logic rs, input logic st, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic er, input logic rd);
    logic [W:0] sum;
    logic [W-1:0] oa, ob, os;
    oa = m_a; ob = m_b; os = m_s;
    if (!rs) begin
      m_st = 0; m_a = 0; m_b = 0; m_s = 0; m_c = 0; m_k = 0;
    end else if (st) begin
      sum = {1'b0, a} + {1'b0, b};
      m_a = a; m_b = b; m_s = sum[W-1:0]; m_c = sum[W]; m_k = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (er) begin
        if (m_k > 0) begin
          m_b = oa; m_a = ob - oa; m_s = ob; m_c = 0; m_k = m_k - 1; m_st = 2;
        end
      end else if (rd) begin
        if (m_c || (m_k + 1 == MAXK)) begin
          m_st = 3;
        end else begin
          sum = {1'b0, ob} + {1'b0, os};
          m_a = ob; m_b = os; m_s = sum[W-1:0]; m_c = sum[W]; m_k = m_k + 1;
        end
      end
    end else if (m_st == 2) begin
      m_st = 1;
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic v, bz;
    v  = (m_st == 1);
    bz = (m_st == 1) || (m_st == 2);
    return {v, bz, m_c, CNT_W'(m_k), m_b, m_s};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rs, input logic st, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic er, input logic rd);
    rst_n = rs; start = st; a_in = a; b_in = b; err_flag = er; out_ready = rd;
    @(posedge clk);
    model_edge(rs, st, a, b, er, rd);
    exp_q.push_back(model_vec());
    #1;
    check("sb", 32'({out_valid, busy, ovf, k_out, b_out, s_out}), 32'(exp_q.pop_front()));
  endtask

  task automatic go(input logic er, input logic rd);
    step(1'b1, 1'b0, 8'h00, 8'h00, er, rd);
  endtask

  task automatic restart(input logic [W-1:0] a, input logic [W-1:0] b);
    step(1'b1, 1'b1, a, b, 1'b0, 1'b1);
  endtask

  initial begin
    m_st = 0; m_a = 0; m_b = 0; m_s = 0; m_c = 0; m_k = 0;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; err_flag = 1'b0; out_ready = 1'b0;

    // Reset, with start asserted to confirm reset wins.
    step(1'b0, 1'b1, 8'd7, 8'd9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_s",     32'(s_out), 32'd0);
    go(1'b0, 1'b1);
    check("idle_valid", 32'(out_valid), 32'd0);

    // Basic sequence 2,3,5 then backpressure at 5.
    restart(8'd1, 8'd1);
    check("seq_s0", 32'(s_out), 32'd2);
    check("seq_k0", 32'(k_out), 32'd0);
    go(1'b0, 1'b1);
    check("seq_s1", 32'(s_out), 32'd3);
    go(1'b0, 1'b1);
    check("seq_s2", 32'(s_out), 32'd5);
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b0);
      check("bp_s", 32'(s_out), 32'd5);
      check("bp_b", 32'(b_out), 32'd3);
      check("bp_k", 32'(k_out), 32'd2);
      check("bp_v", 32'(out_valid), 32'd1);
    end
    go(1'b0, 1'b1);
    check("seq_s3", 32'(s_out), 32'd8);
    check("seq_b3", 32'(b_out), 32'd5);

    // Rollback at 8: one BACK cycle (err held, ignored), then 5/3/2.
    go(1'b1, 1'b1);
    check("back_v", 32'(out_valid), 32'd0);
    check("back_busy", 32'(busy), 32'd1);
    go(1'b1, 1'b0);
    check("rb_s", 32'(s_out), 32'd5);
    check("rb_b", 32'(b_out), 32'd3);
    check("rb_k", 32'(k_out), 32'd2);
    check("rb_v", 32'(out_valid), 32'd1);

    // err at k=0 is a no-op.
    restart(8'd1, 8'd1);
    go(1'b1, 1'b1);
    check("err0_s", 32'(s_out), 32'd2);
    check("err0_k", 32'(k_out), 32'd0);
    check("err0_v", 32'(out_valid), 32'd1);

    // Overflow: k=11 shows 377 mod 256 = 121 with carry, then DONE.
    for (int i = 0; i < 11; i++) go(1'b0, 1'b1);
    check("ovf_k", 32'(k_out), 32'd11);
    check("ovf_s", 32'(s_out), 32'd121);
    check("ovf_c", 32'(ovf), 32'd1);
    go(1'b0, 1'b1);
    check("done_v", 32'(out_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_s", 32'(s_out), 32'd121);
    go(1'b1, 1'b1);
    check("done_hold", 32'(s_out), 32'd121);

    // Restart from DONE, then restart mid-run.
    restart(8'd2, 8'd3);
    check("rs_done_s", 32'(s_out), 32'd5);
    check("rs_done_v", 32'(out_valid), 32'd1);
    go(1'b0, 1'b1);
    go(1'b0, 1'b1);
    restart(8'd2, 8'd3);
    check("rs_run_s", 32'(s_out), 32'd5);
    check("rs_run_k", 32'(k_out), 32'd0);

    // Mid-run reset.
    go(1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("mrst_v", 32'(out_valid), 32'd0);
    check("mrst_s", 32'(s_out), 32'd0);
    check("mrst_k", 32'(k_out), 32'd0);

    // MAXK boundary: zero seeds never carry, so the run ends at k=MAXK-1.
    restart(8'd0, 8'd0);
    for (int i = 0; i < MAXK - 1; i++) go(1'b0, 1'b1);
    check("maxk_k", 32'(k_out), 32'(MAXK - 1));
    check("maxk_v", 32'(out_valid), 32'd1);
    go(1'b0, 1'b1);
    check("maxk_done", 32'(out_valid), 32'd0);
    check("maxk_hold", 32'(k_out), 32'(MAXK - 1));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
           W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_weight_gen.md
FIB_WEIGHT_GEN -- requirements
Module: fib_weight_gen

Interface
REQ-001 The block SHALL have parameter W, default 8: width of every Fibonacci term (A, B, S).
REQ-002 The block SHALL have parameter MAXK, default 24: number of accepted terms after which the run ends.
REQ-003 The block SHALL have parameter CNT_W, default 5: width of the term index, with 2^CNT_W > MAXK.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  load seeds and begin (or restart) a run.
REQ-008 a_in  input  W  seed f(k-2), sampled only when start=1.
REQ-009 b_in  input  W  seed f(k-1), sampled only when start=1.
REQ-010 err_flag  input  1  1 = error; retract one term.
REQ-011 out_ready  input  1  consumer accepts s_out this cycle.
REQ-012 out_valid  output  1  s_out/b_out/k_out/ovf are valid.
REQ-013 s_out  output  W  current term f(k) = A+B, low W bits (registered).
REQ-014 b_out  output  W  current f(k-1) (register B).
REQ-015 k_out  output  CNT_W  index of the current term, 0 after start.
REQ-016 ovf  output  1  carry out of the A+B that produced s_out.
REQ-017 busy  output  1  1 in RUN or BACK.

Function
REQ-018 The block SHALL implement FSM states IDLE, RUN, BACK and DONE, with registers A, B, S (W bits), carry C and index K.
REQ-019 In any state, start=1 SHALL load A<=a_in, B<=b_in, S<=(a_in+b_in) mod 2^W, C<=carry, K<=0, and go to RUN; start has the highest priority.
REQ-020 IDLE SHALL give out_valid=0 and busy=0, and SHALL hold all registers.
REQ-021 RUN SHALL give out_valid=1 and busy=1; s_out=S, b_out=B, k_out=K, ovf=C.
REQ-022 In RUN with err_flag=1 and K>0, the next edge SHALL set B<=A, A<=(B-A) mod 2^W, S<=B, C<=0, K<=K-1, and go to BACK; out_ready SHALL be ignored.
REQ-023 In RUN with err_flag=1 and K=0, the block SHALL hold all registers and stay in RUN.
REQ-024 BACK SHALL give out_valid=0 for exactly one cycle and then return to RUN; err_flag SHALL be ignored in BACK.
REQ-025 In RUN with err_flag=0, out_ready=1 and C=0 and K+1<MAXK (advance), the block SHALL set A<=B, B<=S, S<=(B+S) mod 2^W, C<=carry(B+S), K<=K+1.
REQ-026 In RUN with err_flag=0 and out_ready=1, if C=1 or K+1=MAXK, the term SHALL be accepted and the block SHALL go to DONE with registers held.
REQ-027 In RUN with out_ready=0 and err_flag=0, the block SHALL hold all outputs stable.
REQ-028 DONE SHALL give out_valid=0 and busy=0, and SHALL keep s_out, b_out, k_out and ovf readable; it is left only by start.
REQ-029 All sums and differences SHALL be unsigned modulo 2^W; seeds are not checked for ordering.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE and A=B=S=0, C=0, K=0; this holds in any state, including mid-run, and reset SHALL override start.
REQ-031 The reset values of the outputs SHALL be out_valid=0, s_out=0, b_out=0, k_out=0, ovf=0, busy=0.

Verification
REQ-032 Reset: rst_n=0 for one edge during RUN -> next cycle IDLE; all outputs 0.
REQ-033 Sequence: W=8, start with a_in=1, b_in=1, out_ready=1 -> s_out 2,3,5,8,13 on successive cycles; k_out 0..4; ovf=0.
REQ-034 Backpressure: out_ready=0 for 3 cycles while s_out=5 -> s_out=5, b_out=3, k_out=2 and out_valid=1 held; advances to 8 after out_ready returns to 1.
REQ-035 Error rollback: err_flag=1 with out_ready=1 at s_out=8 (b_out=5, k_out=3) -> 1 cycle with out_valid=0, then s_out=5, b_out=3, k_out=2; err_flag at k_out=0 -> no change.
REQ-036 Overflow: W=8, seeds 1,1, out_ready=1 -> k_out=11 shows s_out=121, ovf=1; next edge -> DONE, out_valid=0, s_out=121 held.
REQ-037 Restart: start=1 asserted in DONE and in RUN with a_in=2, b_in=3 -> next cycle RUN, s_out=5, k_out=0.
